// File: rtl/hazard_pkg.sv
// Shared constants for the RAW hazard scoreboard: forwarding select encodings,
// the hardwired-zero register index and the long-op counter width.
package hazard_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    localparam int REG_X0     = 0;
    localparam int LONG_CNT_W = 3;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard; master is the pipeline,
// slave is the scoreboard itself.
interface hazard_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5
);
    logic                        id_valid;
    logic [NUM_SRC*REG_AW-1:0]   id_rs;
    logic [NUM_SRC-1:0]          id_rs_used;
    logic [REG_AW-1:0]           id_rd;
    logic                        id_regwrite;
    logic                        id_is_long;
    logic [NUM_SRC*REG_AW-1:0]   ex_rs;
    logic [REG_AW-1:0]           ex_rd;
    logic                        ex_memread;
    logic [REG_AW-1:0]           mem_rd;
    logic                        mem_regwrite;
    logic [REG_AW-1:0]           wb_rd;
    logic                        wb_regwrite;
    logic                        lu_done;
    logic [REG_AW-1:0]           lu_rd;
    logic [NUM_SRC*2-1:0]        forward;
    logic                        stall;
    logic                        long_busy;
    logic [2**REG_AW-1:0]        pending;
    logic [31:0]                 perf_lu_stalls;
    logic [31:0]                 perf_sb_stalls;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_long,
               ex_rs, ex_rd, ex_memread, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
               lu_done, lu_rd,
        input  forward, stall, long_busy, pending, perf_lu_stalls, perf_sb_stalls
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_long,
               ex_rs, ex_rd, ex_memread, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
               lu_done, lu_rd,
        output forward, stall, long_busy, pending, perf_lu_stalls, perf_sb_stalls
    );

endinterface

// File: rtl/hazard_scoreboard_fwd_select.sv
// Forwarding select for one EX-stage source operand; EX/MEM has priority
// over MEM/WB and x0 never forwards.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    output logic [1:0]        fwd_o
);

    always_comb begin
        fwd_o = FWD_REGFILE;
        if (mem_regwrite_i && mem_rd_i != REG_AW'(REG_X0) && mem_rd_i == ex_rs_i)
            fwd_o = FWD_EXMEM;
        else if (wb_regwrite_i && wb_rd_i != REG_AW'(REG_X0) && wb_rd_i == ex_rs_i)
            fwd_o = FWD_MEMWB;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard owner for the 5-stage pipeline: EX forwarding, ID stall and the
// long-latency pending scoreboard. Stall-cycle counters exist only when
// HAZARD_PERF_EN is defined.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int MAX_LONG = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  hif
);

    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0]       pending_q, pending_d, eff;
    logic [LONG_CNT_W-1:0] cnt_q, cnt_d;
    logic                  lu_hit, sb_hit, waw_hit, struct_hit, issue;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
        fwd_select #(.REG_AW(REG_AW)) u_fwd (
            .ex_rs_i        (hif.ex_rs[gi*REG_AW +: REG_AW]),
            .mem_rd_i       (hif.mem_rd),
            .mem_regwrite_i (hif.mem_regwrite),
            .wb_rd_i        (hif.wb_rd),
            .wb_regwrite_i  (hif.wb_regwrite),
            .fwd_o          (hif.forward[gi*2 +: 2])
        );
    end

    // A completing long op is already visible to ID this cycle, so its
    // scoreboard bit is masked before hazard detection.
    always_comb begin
        eff = pending_q;
        if (hif.lu_done)
            eff[hif.lu_rd] = 1'b0;
    end

    always_comb begin
        lu_hit = 1'b0;
        sb_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hif.id_rs_used[i]) begin
                if (hif.ex_memread && hif.ex_rd != REG_AW'(REG_X0) &&
                    hif.id_rs[i*REG_AW +: REG_AW] == hif.ex_rd)
                    lu_hit = 1'b1;
                if (eff[hif.id_rs[i*REG_AW +: REG_AW]])
                    sb_hit = 1'b1;
            end
        end
        waw_hit    = hif.id_regwrite && eff[hif.id_rd];
        struct_hit = hif.id_is_long && cnt_q == LONG_CNT_W'(MAX_LONG) && !hif.lu_done;
        hif.stall  = hif.id_valid && (lu_hit || sb_hit || waw_hit || struct_hit);
        issue      = hif.id_valid && !hif.stall && hif.id_is_long;
    end

    // Set is applied after clear so an issue to the completing rd keeps its bit.
    always_comb begin
        pending_d = pending_q;
        if (hif.lu_done)
            pending_d[hif.lu_rd] = 1'b0;
        if (issue && hif.id_regwrite && hif.id_rd != REG_AW'(REG_X0))
            pending_d[hif.id_rd] = 1'b1;
        pending_d[REG_X0] = 1'b0;

        cnt_d = cnt_q;
        if (issue && !hif.lu_done)
            cnt_d = cnt_q + 1'b1;
        else if (!issue && hif.lu_done && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hif.pending   = pending_q;
    assign hif.long_busy = (cnt_q == LONG_CNT_W'(MAX_LONG));

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_q, perf_lu_d, perf_sb_q, perf_sb_d;

    // Load-use takes the blame when several causes coincide.
    always_comb begin
        perf_lu_d = perf_lu_q;
        perf_sb_d = perf_sb_q;
        if (hif.stall && lu_hit) begin
            if (perf_lu_q != '1)
                perf_lu_d = perf_lu_q + 32'd1;
        end else if (hif.stall) begin
            if (perf_sb_q != '1)
                perf_sb_d = perf_sb_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q <= '0;
            perf_sb_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_sb_q <= perf_sb_d;
        end
    end

    assign hif.perf_lu_stalls = perf_lu_q;
    assign hif.perf_sb_stalls = perf_sb_q;
`else
    assign hif.perf_lu_stalls = '0;
    assign hif.perf_sb_stalls = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed walk through the hazard scenarios followed by random traffic,
// all checked against a register-level behavioural model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NUM_SRC  = 2;
    localparam int REG_AW   = 5;
    localparam int MAX_LONG = 2;
    localparam int NREG     = 2**REG_AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) hif ();

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .MAX_LONG(MAX_LONG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: which registers await a long result, how many long ops are in flight.
    bit      m_pend [NREG];
    int      m_cnt;
    longint  m_lu, m_sb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REG_AW-1:0] rs_of(input logic [NUM_SRC*REG_AW-1:0] v, input int i);
        return v[i*REG_AW +: REG_AW];
    endfunction

    function automatic bit busy_reg(input int r);
        return m_pend[r] && !(hif.lu_done && int'(hif.lu_rd) == r);
    endfunction

    // 0: no stall, 1: load-use stall, 2: stall for any other reason
    function automatic int m_cause();
        bit lu = 0, other = 0;
        if (!hif.id_valid) return 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hif.id_rs_used[i]) begin
                if (hif.ex_memread && hif.ex_rd != 0 && rs_of(hif.id_rs, i) == hif.ex_rd) lu = 1;
                if (busy_reg(int'(rs_of(hif.id_rs, i)))) other = 1;
            end
        end
        if (hif.id_regwrite && busy_reg(int'(hif.id_rd))) other = 1;
        if (hif.id_is_long && m_cnt == MAX_LONG && !hif.lu_done) other = 1;
        return lu ? 1 : (other ? 2 : 0);
    endfunction

    function automatic logic [1:0] m_fwd(input int i);
        logic [REG_AW-1:0] rs = rs_of(hif.ex_rs, i);
        if (hif.mem_regwrite && hif.mem_rd != 0 && hif.mem_rd == rs) return 2'b10;
        if (hif.wb_regwrite && hif.wb_rd != 0 && hif.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        foreach (m_pend[r]) m_pend[r] = 0;
        m_cnt = 0; m_lu = 0; m_sb = 0;
    endtask

    task automatic idle();
        hif.id_valid = 0; hif.id_rs = '0; hif.id_rs_used = '0; hif.id_rd = '0;
        hif.id_regwrite = 0; hif.id_is_long = 0; hif.ex_rs = '0; hif.ex_rd = '0;
        hif.ex_memread = 0; hif.mem_rd = '0; hif.mem_regwrite = 0; hif.wb_rd = '0;
        hif.wb_regwrite = 0; hif.lu_done = 0; hif.lu_rd = '0;
    endtask

    task automatic check_all(input string tag);
        logic [NREG-1:0] pv = '0;
        int c = m_cause();
        for (int r = 0; r < NREG; r++) pv[r] = m_pend[r];
        for (int i = 0; i < NUM_SRC; i++) chk({tag, ".fwd"}, 64'(hif.forward[i*2 +: 2]), 64'(m_fwd(i)));
        chk({tag, ".stall"}, 64'(hif.stall), 64'(c != 0));
        chk({tag, ".pending"}, 64'(hif.pending), 64'(pv));
        chk({tag, ".busy"}, 64'(hif.long_busy), 64'(m_cnt == MAX_LONG));
`ifdef HAZARD_PERF_EN
        chk({tag, ".perf_lu"}, 64'(hif.perf_lu_stalls), 64'(m_lu));
        chk({tag, ".perf_sb"}, 64'(hif.perf_sb_stalls), 64'(m_sb));
`else
        chk({tag, ".perf_lu"}, 64'(hif.perf_lu_stalls), 64'd0);
        chk({tag, ".perf_sb"}, 64'(hif.perf_sb_stalls), 64'd0);
`endif
    endtask

    // Advance one clock, updating the model from the inputs held before the edge.
    task automatic tick();
        int c   = m_cause();
        bit iss = hif.id_valid && c == 0 && hif.id_is_long;
        if (hif.lu_done) m_pend[hif.lu_rd] = 0;
        if (iss && hif.id_regwrite && hif.id_rd != 0) m_pend[hif.id_rd] = 1;
        if (iss && !hif.lu_done) m_cnt++;
        else if (!iss && hif.lu_done && m_cnt > 0) m_cnt--;
        if (c == 1 && m_lu < 64'hFFFF_FFFF) m_lu++;
        if (c == 2 && m_sb < 64'hFFFF_FFFF) m_sb++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_long(input logic [REG_AW-1:0] rd);
        idle();
        hif.id_valid = 1; hif.id_is_long = 1; hif.id_regwrite = 1; hif.id_rd = rd;
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        chk("rst.pending", 64'(hif.pending), 64'd0);
        chk("rst.busy", 64'(hif.long_busy), 64'd0);
        chk("rst.stall", 64'(hif.stall), 64'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Forwarding priority and x0
        hif.ex_rs = {5'd2, 5'd1}; hif.mem_rd = 5'd1; hif.mem_regwrite = 1;
        hif.wb_rd = 5'd2; hif.wb_regwrite = 1; #1;
        chk("fwd.split", 64'(hif.forward), 64'(4'b01_10));
        hif.wb_rd = 5'd1; #1;
        chk("fwd.exmem_wins", 64'(hif.forward), 64'(4'b00_10));
        hif.ex_rs = '0; hif.mem_rd = 5'd0; hif.wb_rd = 5'd0; #1;
        chk("fwd.x0", 64'(hif.forward), 64'd0);
        check_all("fwd");

        // Load-use held for four cycles, then released
        idle();
        hif.id_valid = 1; hif.id_rs = {5'd0, 5'd5}; hif.id_rs_used = 2'b01;
        hif.ex_memread = 1; hif.ex_rd = 5'd5; #1;
        chk("lu.stall", 64'(hif.stall), 64'd1);
        hif.id_rs_used = 2'b00; #1;
        chk("lu.unused", 64'(hif.stall), 64'd0);
        hif.id_rs_used = 2'b01;
        repeat (4) tick();
        hif.ex_memread = 0; #1;
        chk("lu.release", 64'(hif.stall), 64'd0);
`ifdef HAZARD_PERF_EN
        chk("lu.perf4", 64'(hif.perf_lu_stalls), 64'd4);
`endif
        check_all("lu");

        // Scoreboard RAW on a DIV result, released by same-cycle completion
        issue_long(5'd7); #1;
        chk("sb.issue_stall", 64'(hif.stall), 64'd0);
        tick();
        chk("sb.pend7", 64'(hif.pending[7]), 64'd1);
        idle();
        hif.id_valid = 1; hif.id_rs = {5'd0, 5'd7}; hif.id_rs_used = 2'b01;
        hif.id_rd = 5'd8; hif.id_regwrite = 1; #1;
        chk("sb.raw", 64'(hif.stall), 64'd1);
        tick();
        chk("sb.raw_held", 64'(hif.stall), 64'd1);
        hif.lu_done = 1; hif.lu_rd = 5'd7; #1;
        chk("sb.bypass", 64'(hif.stall), 64'd0);
        tick();
        idle(); #1;
        chk("sb.clear7", 64'(hif.pending[7]), 64'd0);
        check_all("sb");

        // Structural limit, then completion-and-issue in one cycle
        issue_long(5'd3); tick();
        issue_long(5'd4); tick();
        chk("st.busy", 64'(hif.long_busy), 64'd1);
        issue_long(5'd9); #1;
        chk("st.stall", 64'(hif.stall), 64'd1);
        hif.lu_done = 1; hif.lu_rd = 5'd3; #1;
        chk("st.issue_on_done", 64'(hif.stall), 64'd0);
        tick();
        chk("st.busy_kept", 64'(hif.long_busy), 64'd1);
        issue_long(5'd7); hif.lu_done = 1; hif.lu_rd = 5'd4; tick();
        issue_long(5'd3); hif.lu_done = 1; hif.lu_rd = 5'd9; tick();
        idle(); #1;
        chk("st.pend37", 64'(hif.pending), 64'(32'h0000_0088));
        check_all("st");

        // Asynchronous reset between edges
        #2 rst_n = 0; #1;
        chk("arst.pending", 64'(hif.pending), 64'd0);
        chk("arst.busy", 64'(hif.long_busy), 64'd0);
        model_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        check_all("arst");

        // Random traffic on a narrow register window so hazards are common
        for (int n = 0; n < 400; n++) begin
            hif.id_valid     = ($urandom_range(0, 9) < 8);
            hif.id_rs        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            hif.id_rs_used   = 2'($urandom);
            hif.id_rd        = 5'($urandom_range(0, 7));
            hif.id_regwrite  = 1'($urandom);
            hif.id_is_long   = ($urandom_range(0, 2) == 0);
            hif.ex_rs        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            hif.ex_rd        = 5'($urandom_range(0, 7));
            hif.ex_memread   = ($urandom_range(0, 3) == 0);
            hif.mem_rd       = 5'($urandom_range(0, 7));
            hif.mem_regwrite = 1'($urandom);
            hif.wb_rd        = 5'($urandom_range(0, 7));
            hif.wb_regwrite  = 1'($urandom);
            hif.lu_done      = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            hif.lu_rd        = 5'($urandom_range(0, 7));
            #1;
            check_all($sformatf("rnd%0d", n));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Successor to the two-source EX-stage forwarding unit: one block owns all RAW data-hazard handling for the 5-stage RV32IM pipeline.
- Forwarding selects are generated for NUM_SRC EX-stage sources.
- It raises ID-stage stall for load-use hazards and for hazards on results from the multi-cycle MUL/DIV unit.
- A per-register pending scoreboard tracks in-flight long-latency writes, set at ID issue and cleared at unit completion.
- Sits beside the ID/EX pipeline registers; drives the EX operand muxes and the PC/IF-ID hold logic.

Parameters:
- NUM_SRC, 2, number of source operands checked per instruction (1..3).
- REG_AW, 5, register address width; the scoreboard has 2**REG_AW bits.
- MAX_LONG, 2, maximum in-flight long ops (1..7); counter width is 3.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction (low on bubble/flush)
- id_rs  in  NUM_SRC*REG_AW  ID source regs, packed, src0 in LSBs
- id_rs_used  in  NUM_SRC  per-source read enable
- id_rd  in  REG_AW  ID destination
- id_regwrite  in  1  ID instruction writes rd
- id_is_long  in  1  ID instruction goes to the MUL/DIV unit
- ex_rs  in  NUM_SRC*REG_AW  EX source regs, packed
- ex_rd  in  REG_AW  EX destination
- ex_memread  in  1  EX instruction is a load
- mem_rd  in  REG_AW  EX/MEM destination
- mem_regwrite  in  1  EX/MEM writes rd
- wb_rd  in  REG_AW  MEM/WB destination
- wb_regwrite  in  1  MEM/WB writes rd
- lu_done  in  1  long unit result written back this cycle
- lu_rd  in  REG_AW  destination of completing long op
- forward  out  NUM_SRC*2  per-source select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall  out  1  hold PC and IF/ID; inject a bubble into ID/EX
- long_busy  out  1  outstanding count == MAX_LONG
- pending  out  2**REG_AW  registered scoreboard, bit 0 always 0
- perf_lu_stalls  out  32  load-use stall cycles (optional feature)
- perf_sb_stalls  out  32  scoreboard stall cycles (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, outstanding count=0, perf counters=0.
  - Combinational outputs follow their inputs with zero state.
  - Reset mid-operation drops all in-flight tracking; the pipeline flushes alongside.
- forward[i], combinational:
  - 10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs[i].
  - Otherwise 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs[i].
  - Otherwise 00.
  - EX/MEM wins over MEM/WB. x0 never forwards.
- Effective scoreboard: eff = pending & ~(lu_done ? onehot(lu_rd) : 0). The same-cycle completion bypass removes one stall cycle.
- stall, combinational, asserted only when id_valid is high. Conditions:
  - Load-use: ex_memread && ex_rd!=0 && some used id_rs[i]==ex_rd.
  - Scoreboard RAW: some used id_rs[i] has eff bit set.
  - WAW: id_regwrite && eff[id_rd].
  - Structural: id_is_long && count==MAX_LONG && !lu_done.
- Issue = id_valid && !stall && id_is_long.
  - Sets pending[id_rd] next edge when id_regwrite && id_rd!=0.
  - Count increments on issue.
- Completion: lu_done clears pending[lu_rd] and decrements count.
  - Issue and completion in the same cycle: count unchanged. If both target the same rd, set wins.
  - lu_done with count==0: the decrement is ignored (saturate at 0); the clear still applies.
- Latency:
  - forward and stall: 0 cycles.
  - pending and long_busy: 1 cycle after issue/completion.
- pending[0] is hardwired 0.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_lu_stalls increments each cycle a stall is due to load-use.
  - Otherwise perf_sb_stalls increments each cycle a stall is due to scoreboard, WAW or structural causes.
  - When both causes hold, it is attributed to load-use.
  - Both counters are 32-bit and saturate at all-ones.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_REGFILE=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
  - REG_X0 constant.
  - Long-op counter width.
- One natural sub-module: fwd_select.
  - Purely combinational; computes a single source's 2-bit select.
  - Instantiated NUM_SRC times in a generate loop.

Test Plan:
- ex_rs={2,1}, mem_rd=1/mem_regwrite=1, wb_rd=2/wb_regwrite=1 -> forward={01,10}. mem_rd=wb_rd=1 -> src0 stays 10. mem_rd=0 with rs=0 -> 00.
- Load-use: ex_memread=1, ex_rd=5, id_rs0=5 used -> stall=1 for exactly that cycle. Same with id_rs_used0=0 -> stall=0.
- Scoreboard, step 1: issue DIV with id_rd=7 -> pending[7]=1 next cycle. A following instruction reading x7 -> stall held.
- Scoreboard, step 2: lu_done with lu_rd=7 -> stall drops in the same cycle, and pending[7]=0 next cycle.
- MAX_LONG=2, two long issues without completion -> long_busy=1 and a third long op stalls. Asserting lu_done in that cycle -> it issues, and count stays 2.
- Assert rst_n low asynchronously with pending={3,7} set and count=2 -> pending=0, long_busy=0 before the next clk edge. Under HAZARD_PERF_EN, 4 load-use stall cycles -> perf_lu_stalls=4.
